// File: rtl/bus_switch_pkg.sv
// Purpose: shared types and idle pin values for the SRAM/UART bus owner switch.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package bus_switch_pkg;

    typedef enum logic [1:0] {
        OWN   = 2'd0,
        DRAIN = 2'd1,
        GAP   = 2'd2
    } sw_state_t;

    // Control strobe bundle, MSB first: {data_oe, en_n, oe_n, we_n, rdn, wrn}.
    // Idle means nobody drives data and every active-low strobe is released.
    localparam int              CTRL_W    = 6;
    localparam logic [CTRL_W-1:0] CTRL_IDLE = 6'b011111;

endpackage

// File: rtl/bus_mux_reg.sv
// Purpose: N-to-1 registered mux with a force-idle override, used for the pin path.
// Latency: 1 cycle from din/sel to dout.
// Backpressure: none; dout is rewritten every cycle.
// Ports: clk, rst (async active-high, loads IDLE), sel (channel index),
//        force_idle (load IDLE this cycle), din (N packed W-bit words), dout.
module bus_mux_reg #(
    parameter int           N     = 4,
    parameter int           W     = 8,
    parameter int           SEL_W = 2,
    parameter logic [W-1:0] IDLE  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] sel,
    input  logic             force_idle,
    input  logic [N*W-1:0]   din,
    output logic [W-1:0]     dout
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= IDLE;
        end else if (force_idle || int'(sel) >= N) begin
            dout <= IDLE;
        end else begin
            dout <= din[int'(sel)*W +: W];
        end
    end

endmodule

// File: rtl/bus_owner_switch.sv
// Purpose: hands the shared SRAM/UART pin bus to one client channel at a time, with drain + dead-time gap.
// Latency: pins follow the owner's signals 1 cycle late; an owner change takes drain + GAP_CYC cycles.
// Backpressure: owner is held until its busy drops (or DRAIN_MAX forces it); clients wait while switching=1.
// Ports: clk, rst (async active-high); sel_in requested owner; per-channel ch_* busy/addr/wdata/strobes;
//        ram_rdata from the pin wrapper; ch_grant one-hot grant; ch_rdata broadcast read data;
//        registered ram_*/uart_* pins; owner, switching, err_timeout (sticky), err_bad_sel (pulse).
module bus_owner_switch
    import bus_switch_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int AW        = 18,
    parameter int DW        = 16,
    parameter int GAP_CYC   = 2,
    parameter int DRAIN_MAX = 255,
    parameter int SEL_W     = $clog2(N_CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SEL_W-1:0]    sel_in,
    input  logic [N_CH-1:0]     ch_busy,
    input  logic [N_CH*AW-1:0]  ch_addr,
    input  logic [N_CH*DW-1:0]  ch_wdata,
    input  logic [N_CH-1:0]     ch_data_oe,
    input  logic [N_CH-1:0]     ch_en_n,
    input  logic [N_CH-1:0]     ch_oe_n,
    input  logic [N_CH-1:0]     ch_we_n,
    input  logic [N_CH-1:0]     ch_rdn,
    input  logic [N_CH-1:0]     ch_wrn,
    input  logic [DW-1:0]       ram_rdata,
    output logic [N_CH-1:0]     ch_grant,
    output logic [DW-1:0]       ch_rdata,
    output logic [AW-1:0]       ram_addr,
    output logic [DW-1:0]       ram_wdata,
    output logic                ram_data_oe,
    output logic                ram_en_n,
    output logic                ram_oe_n,
    output logic                ram_we_n,
    output logic                uart_rdn,
    output logic                uart_wrn,
    output logic [SEL_W-1:0]    owner,
    output logic                switching,
    output logic                err_timeout,
    output logic                err_bad_sel
);

    localparam int PW  = AW + DW + CTRL_W;
    localparam int GW  = $clog2(GAP_CYC + 1);
    localparam int DCW = $clog2(DRAIN_MAX + 1);
    localparam logic [GW-1:0]  GAP_LAST   = GW'(GAP_CYC - 1);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_MAX - 1);
    localparam logic [PW-1:0]  PIN_IDLE   = {{(AW + DW){1'b0}}, CTRL_IDLE};

    sw_state_t        state;
    logic [SEL_W-1:0] target;
    logic [GW-1:0]    gap_cnt;
    logic [DCW-1:0]   drain_cnt;
    logic             bad_q;

    logic             sel_ok;
    logic             go_gap;
    logic [SEL_W-1:0] nxt_owner;
    logic [N_CH*PW-1:0] pin_in;
    logic [PW-1:0]    pin_q;

    assign ch_rdata  = ram_rdata;
    assign sel_ok    = int'(sel_in) < N_CH;
    // An invalid request on the last gap cycle falls back to the previous target.
    assign nxt_owner = sel_ok ? sel_in : target;
    // Leaving DRAIN this cycle: idle the pins on the same edge the grant drops.
    assign go_gap    = (state == DRAIN) && (sel_in != owner) &&
                       (!ch_busy[owner] || drain_cnt == DRAIN_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= GAP;
            target      <= '0;
            owner       <= '0;
            gap_cnt     <= '0;
            drain_cnt   <= '0;
            ch_grant    <= '0;
            switching   <= 1'b1;
            err_timeout <= 1'b0;
            err_bad_sel <= 1'b0;
            bad_q       <= 1'b0;
        end else begin
            bad_q       <= !sel_ok;
            err_bad_sel <= !sel_ok && !bad_q;
            case (state)
                OWN: begin
                    if (sel_ok && sel_in != owner) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                        switching <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (sel_in == owner) begin
                        state     <= OWN;
                        switching <= 1'b0;
                    end else if (go_gap) begin
                        if (ch_busy[owner]) begin
                            err_timeout <= 1'b1;
                        end
                        state    <= GAP;
                        gap_cnt  <= '0;
                        ch_grant <= '0;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: begin
                    if (gap_cnt == GAP_LAST) begin
                        state     <= OWN;
                        switching <= 1'b0;
                        owner     <= nxt_owner;
                        target    <= nxt_owner;
                        ch_grant  <= N_CH'(1) << nxt_owner;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_pack
        assign pin_in[i*PW +: PW] = {ch_addr[i*AW +: AW], ch_wdata[i*DW +: DW],
                                     ch_data_oe[i], ch_en_n[i], ch_oe_n[i],
                                     ch_we_n[i], ch_rdn[i], ch_wrn[i]};
    end

    bus_mux_reg #(
        .N     (N_CH),
        .W     (PW),
        .SEL_W (SEL_W),
        .IDLE  (PIN_IDLE)
    ) u_pin_mux (
        .clk        (clk),
        .rst        (rst),
        .sel        (owner),
        .force_idle ((state == GAP) || go_gap),
        .din        (pin_in),
        .dout       (pin_q)
    );

    assign {ram_addr, ram_wdata, ram_data_oe, ram_en_n, ram_oe_n,
            ram_we_n, uart_rdn, uart_wrn} = pin_q;

endmodule
